// File: rtl/magnet_pkg.sv
// Shared definitions for the magnet coil PWM drivers: FSM encoding, PWM count range
// and the bounded slew step used by the duty ramp.
package magnet_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RAMP  = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [7:0] PWM_MAX      = 8'd255;
  localparam logic [7:0] PWM_LAST_CNT = 8'd254;

  // One slew step toward cmd, done in 9 bits so neither direction can wrap.
  function automatic logic [7:0] ramp_next(input logic [7:0] act,
                                           input logic [7:0] cmd,
                                           input logic [7:0] step);
    logic [8:0] act9;
    logic [8:0] cmd9;
    logic [8:0] step9;
    logic [8:0] res9;
    act9  = {1'b0, act};
    cmd9  = {1'b0, cmd};
    step9 = {1'b0, step};
    if (cmd9 > act9) begin
      res9 = act9 + step9;
      if (res9 > cmd9) begin
        res9 = cmd9;
      end else begin
        res9 = res9;
      end
    end else if (cmd9 < act9) begin
      if (act9 < (cmd9 + step9)) begin
        res9 = cmd9;
      end else begin
        res9 = act9 - step9;
      end
    end else begin
      res9 = act9;
    end
    return res9[7:0];
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// PWM timebase: prescaler feeding a 0..254 count, with the period-boundary strobe
// and a registered one-cycle tick at the first cycle of each period.
module pwm_timebase
  import magnet_pkg::*;
#(
  parameter int PRESCALE = 196
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] cnt_o,
  output logic       pb_o,
  output logic       period_tick_o
);

  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;
  logic [PW-1:0] presc_d;
  logic [7:0]    cnt_q;
  logic [7:0]    cnt_d;
  logic          tick_q;
  logic          adv_s;
  logic          pb_s;

  always_comb begin
    adv_s   = (presc_q == PRE_LAST);
    pb_s    = adv_s && (cnt_q == PWM_LAST_CNT);
    presc_d = adv_s ? '0 : (presc_q + PW'(1));
    if (!adv_s) begin
      cnt_d = cnt_q;
    end else if (pb_s) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      cnt_q   <= 8'd0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= pb_s;
    end
  end

  assign cnt_o         = cnt_q;
  assign pb_o          = pb_s;
  assign period_tick_o = tick_q;

endmodule

// File: rtl/magnet_pwm_driver.sv
// Magnet coil PWM driver: slews the applied duty toward the PIO command once per period
// and forces the coil off on a latched fault until software clears it with a zero command.
module magnet_pwm_driver
  import magnet_pkg::*;
#(
  parameter int PRESCALE  = 196,
  parameter int RAMP_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty_cmd,
  input  logic       fault_in,
  input  logic       fault_clear,
  output logic       pwm_out,
  output logic [7:0] active_duty,
  output logic       fault,
  output logic       period_tick
);

  localparam logic [7:0] STEP = (RAMP_STEP >= 255) ? PWM_MAX : 8'(RAMP_STEP);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic [7:0] act_q;
  logic [7:0] act_d;
  logic       fault_q;
  logic       fault_d;
  logic       pwm_q;
  logic       pwm_d;
  logic [7:0] cnt_s;
  logic       pb_s;
  logic [7:0] ramp_s;

  pwm_timebase #(
    .PRESCALE(PRESCALE)
  ) u_timebase (
    .clk          (clk),
    .reset        (reset),
    .cnt_o        (cnt_s),
    .pb_o         (pb_s),
    .period_tick_o(period_tick)
  );

  // Fault wins over everything; otherwise the command only moves the duty at a period boundary.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    fault_d = fault_q;
    ramp_s  = ramp_next(act_q, duty_cmd, STEP);
    if (fault_in) begin
      state_d = ST_FAULT;
      act_d   = 8'd0;
      fault_d = 1'b1;
    end else if (state_q == ST_FAULT) begin
      if (fault_clear && (duty_cmd == 8'd0)) begin
        state_d = ST_IDLE;
        fault_d = 1'b0;
      end else begin
        state_d = ST_FAULT;
      end
    end else if (pb_s) begin
      act_d = ramp_s;
      if (ramp_s != duty_cmd) begin
        state_d = ST_RAMP;
      end else if (duty_cmd != 8'd0) begin
        state_d = ST_HOLD;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
    pwm_d = (cnt_s < act_q) && !fault_q && (state_q != ST_FAULT) && !fault_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      act_q   <= 8'd0;
      fault_q <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      fault_q <= fault_d;
      pwm_q   <= pwm_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign active_duty = act_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_magnet_pwm_driver.sv
// Self-checking bench for magnet_pwm_driver (PRESCALE=2, RAMP_STEP=8, period 510 clks)
// against a time-indexed behavioural model of the coil drive.
module tb_magnet_pwm_driver;

  localparam int PERIOD = 510;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] duty_cmd;
  logic       fault_in;
  logic       fault_clear;
  logic       pwm_out;
  logic [7:0] active_duty;
  logic       fault;
  logic       period_tick;

  int n_pass   = 0;
  int n_checks = 0;

  // Reference model: position in the period, applied duty, fault flag, expected outputs.
  int         m_t = 0;
  logic [7:0] m_act = 8'd0;
  bit         m_fault = 1'b0;
  bit         m_pwm = 1'b0;
  bit         m_tick = 1'b0;

  always #5 clk = ~clk;

  magnet_pwm_driver #(
    .PRESCALE (2),
    .RAMP_STEP(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .duty_cmd   (duty_cmd),
    .fault_in   (fault_in),
    .fault_clear(fault_clear),
    .pwm_out    (pwm_out),
    .active_duty(active_duty),
    .fault      (fault),
    .period_tick(period_tick)
  );

  function automatic int ref_ramp(int act, int cmd);
    if (cmd > act) return (act + 8 < cmd) ? act + 8 : cmd;
    if (cmd < act) return (act - 8 > cmd) ? act - 8 : cmd;
    return act;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_t     <= 0;
      m_act   <= 8'd0;
      m_fault <= 1'b0;
      m_pwm   <= 1'b0;
      m_tick  <= 1'b0;
    end else begin
      m_t    <= (m_t + 1) % PERIOD;
      m_tick <= (m_t == PERIOD - 1);
      m_pwm  <= ((m_t / 2) < int'(m_act)) && !m_fault && !fault_in;
      if (fault_in) begin
        m_fault <= 1'b1;
        m_act   <= 8'd0;
      end else if (m_fault) begin
        if (fault_clear && duty_cmd == 8'd0) m_fault <= 1'b0;
      end else if (m_t == PERIOD - 1) begin
        m_act <= 8'(ref_ramp(int'(m_act), int'(duty_cmd)));
      end
    end
  end

  task automatic test_reset();
    int ticks;
    int last_tick;
    int highs;
    reset = 1'b1; duty_cmd = 8'd0; fault_in = 1'b0; fault_clear = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 1'b0 || active_duty !== 8'd0 || fault !== 1'b0 || period_tick !== 1'b0)
      $display("FAIL reset_state: got pwm=%b act=%0d fault=%b tick=%b, want all 0",
               pwm_out, active_duty, fault, period_tick);
    else n_pass++;
    reset = 1'b0;
    ticks = 0; last_tick = 0; highs = 0;
    for (int i = 1; i <= 3 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_reset @%0t: got pwm=%b act=%0d fault=%b tick=%b want pwm=%b act=%0d fault=%b tick=%b",
                 $time, pwm_out, active_duty, fault, period_tick, m_pwm, m_act, m_fault, m_tick);
      else n_pass++;
      if (pwm_out === 1'b1) highs++;
      if (period_tick === 1'b1) begin
        ticks++;
        n_checks++;
        if (i - last_tick != PERIOD)
          $display("FAIL tick_spacing: got %0d clks, want %0d", i - last_tick, PERIOD);
        else n_pass++;
        last_tick = i;
      end
    end
    n_checks++;
    if (ticks != 3 || highs != 0)
      $display("FAIL idle_periods: got ticks=%0d pwm_high=%0d, want ticks=3 pwm_high=0", ticks, highs);
    else n_pass++;
  endtask

  task automatic test_ramp_up();
    int k;
    int highs;
    duty_cmd = 8'd40;
    k = 0;
    for (int i = 0; i < 6 * PERIOD && k < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_ramp_up @%0t: got pwm=%b act=%0d fault=%b tick=%b want pwm=%b act=%0d fault=%b tick=%b",
                 $time, pwm_out, active_duty, fault, period_tick, m_pwm, m_act, m_fault, m_tick);
      else n_pass++;
      if (m_tick) begin
        n_checks++;
        if (active_duty !== 8'(8 * (k + 1)))
          $display("FAIL ramp_up_step%0d: got %0d, want %0d", k, active_duty, 8 * (k + 1));
        else n_pass++;
        k++;
      end
    end
    n_checks++;
    if (k != 5) $display("FAIL ramp_up_timeout: got %0d steps, want 5", k);
    else n_pass++;
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_hold40 @%0t: got pwm=%b act=%0d want pwm=%b act=%0d",
                 $time, pwm_out, active_duty, m_pwm, m_act);
      else n_pass++;
      if (pwm_out === 1'b1) highs++;
    end
    n_checks++;
    if (highs != 80) $display("FAIL hold40_high_clks: got %0d, want 80", highs);
    else n_pass++;
  endtask

  task automatic test_mid_period();
    int highs;
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_mid @%0t: got pwm=%b act=%0d want pwm=%b act=%0d",
                 $time, pwm_out, active_duty, m_pwm, m_act);
      else n_pass++;
      if (pwm_out === 1'b1) highs++;
      if (m_t == 20) duty_cmd = 8'd100;
    end
    n_checks++;
    if (highs != 80 || active_duty !== 8'd48)
      $display("FAIL mid_period_change: got high=%0d act=%0d, want high=80 act=48", highs, active_duty);
    else n_pass++;
    duty_cmd = 8'd40;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_back40 @%0t: got pwm=%b act=%0d want pwm=%b act=%0d",
                 $time, pwm_out, active_duty, m_pwm, m_act);
      else n_pass++;
    end
    n_checks++;
    if (active_duty !== 8'd40) $display("FAIL back_to_40: got %0d, want 40", active_duty);
    else n_pass++;
  endtask

  task automatic test_fault();
    int k;
    for (int i = 0; i < PERIOD && m_t != 30; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_prefault @%0t: got pwm=%b act=%0d want pwm=%b act=%0d",
                 $time, pwm_out, active_duty, m_pwm, m_act);
      else n_pass++;
    end
    fault_in = 1'b1;
    @(negedge clk);
    fault_in = 1'b0;
    n_checks++;
    if (pwm_out !== 1'b0 || fault !== 1'b1 || active_duty !== 8'd0)
      $display("FAIL fault_entry: got pwm=%b fault=%b act=%0d, want pwm=0 fault=1 act=0",
               pwm_out, fault, active_duty);
    else n_pass++;
    repeat (5) @(negedge clk);
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (fault !== 1'b1 || pwm_out !== 1'b0)
      $display("FAIL clear_nonzero_cmd: got fault=%b pwm=%b, want fault=1 pwm=0", fault, pwm_out);
    else n_pass++;
    duty_cmd = 8'd0;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    n_checks++;
    if (fault !== 1'b0) $display("FAIL clear_zero_cmd: got fault=%b, want 0", fault);
    else n_pass++;
    duty_cmd = 8'd40;
    k = 0;
    for (int i = 0; i < 6 * PERIOD && k < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_restart @%0t: got pwm=%b act=%0d fault=%b want pwm=%b act=%0d fault=%b",
                 $time, pwm_out, active_duty, fault, m_pwm, m_act, m_fault);
      else n_pass++;
      if (m_tick) begin
        k++;
        if (k == 1) begin
          n_checks++;
          if (active_duty !== 8'd8) $display("FAIL restart_from_zero: got %0d, want 8", active_duty);
          else n_pass++;
        end
      end
    end
    n_checks++;
    if (active_duty !== 8'd40 || k != 5)
      $display("FAIL restart_hold: got act=%0d steps=%0d, want act=40 steps=5", active_duty, k);
    else n_pass++;
  endtask

  task automatic test_ramp_down_extremes();
    int k;
    int highs;
    duty_cmd = 8'd0;
    k = 0;
    for (int i = 0; i < 6 * PERIOD && k < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_ramp_down @%0t: got pwm=%b act=%0d want pwm=%b act=%0d",
                 $time, pwm_out, active_duty, m_pwm, m_act);
      else n_pass++;
      if (m_tick) begin
        n_checks++;
        if (active_duty !== 8'(32 - 8 * k))
          $display("FAIL ramp_down_step%0d: got %0d, want %0d", k, active_duty, 32 - 8 * k);
        else n_pass++;
        k++;
      end
    end
    duty_cmd = 8'd255;
    k = 0;
    for (int i = 0; i < 33 * PERIOD && k < 32; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_to_full @%0t: got pwm=%b act=%0d want pwm=%b act=%0d",
                 $time, pwm_out, active_duty, m_pwm, m_act);
      else n_pass++;
      if (m_tick) k++;
    end
    n_checks++;
    if (active_duty !== 8'd255) $display("FAIL full_duty_reached: got %0d, want 255", active_duty);
    else n_pass++;
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      if (pwm_out === 1'b1) highs++;
    end
    n_checks++;
    if (highs != PERIOD) $display("FAIL full_duty_constant: got %0d high clks, want %0d", highs, PERIOD);
    else n_pass++;
  endtask

  task automatic test_corners();
    int k;
    duty_cmd = 8'd0;
    fault_in = 1'b1;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_in = 1'b0;
    n_checks++;
    if (fault !== 1'b1) $display("FAIL fault_and_clear: got fault=%b, want 1", fault);
    else n_pass++;
    @(negedge clk);
    fault_clear = 1'b0;
    duty_cmd = 8'd40;
    k = 0;
    for (int i = 0; i < 4 * PERIOD && k < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_corner @%0t: got pwm=%b act=%0d fault=%b want pwm=%b act=%0d fault=%b",
                 $time, pwm_out, active_duty, fault, m_pwm, m_act, m_fault);
      else n_pass++;
      if (m_tick) k++;
    end
    n_checks++;
    if (active_duty !== 8'd24) $display("FAIL pre_reset_act: got %0d, want 24", active_duty);
    else n_pass++;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (pwm_out !== 1'b0 || active_duty !== 8'd0 || fault !== 1'b0 || period_tick !== 1'b0)
      $display("FAIL reset_mid_ramp: got pwm=%b act=%0d fault=%b tick=%b, want all 0",
               pwm_out, active_duty, fault, period_tick);
    else n_pass++;
    fault_in = 1'b1;
    @(negedge clk);
    fault_in = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || pwm_out !== 1'b0 || active_duty !== 8'd0)
      $display("FAIL reset_mid_fault: got fault=%b pwm=%b act=%0d, want all 0", fault, pwm_out, active_duty);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20 * PERIOD; i++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== m_pwm || active_duty !== m_act || fault !== m_fault || period_tick !== m_tick)
        $display("FAIL model_random @%0t: got pwm=%b act=%0d fault=%b tick=%b want pwm=%b act=%0d fault=%b tick=%b",
                 $time, pwm_out, active_duty, fault, period_tick, m_pwm, m_act, m_fault, m_tick);
      else n_pass++;
      reset       = ($urandom_range(0, 4999) == 0);
      fault_in    = ($urandom_range(0, 2999) == 0);
      fault_clear = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 299) == 0)
        duty_cmd = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
    end
    reset = 1'b0;
    fault_in = 1'b0;
    fault_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_mid_period();
    test_fault();
    test_ramp_down_extremes();
    test_corners();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
